// File: rtl/jt5205_enc.sv
// jt5205_enc -- serial ADPCM encoder matching the jt5205 decoder.
//
// One PCM sample is turned into one 4-bit ADPCM nibble over six cen ticks:
//   IDLE (accept) -> SUB -> B2 -> B1 -> B0 -> UPD (emit) -> IDLE.
// The predictor tracks what a matching decoder reproduces, so pred is the
// reconstructed sound.
//
// Ports:
//   clk        : single clock for all state
//   rst_n      : asynchronous active-low reset
//   cen        : clock enable; state and datapath change only when cen=1
//   sync_clr   : synchronous clear (qualified by cen), re-aligns with a
//                freshly reset decoder; aborts a sample in flight
//   pcm_in     : signed 12-bit PCM sample
//   pcm_valid  : pcm_in is valid
//   pcm_ready  : encoder accepts a sample on this cen tick (IDLE only)
//   code       : ADPCM nibble {sign, b2, b1, b0}, held between updates
//   code_valid : one-clk pulse when code is updated
//   pred       : signed 12-bit predictor (decoder output level)
module jt5205_enc #(
  parameter logic signed [11:0] REST_LEVEL = -12'sd2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cen,
  input  logic               sync_clr,
  input  logic signed [11:0] pcm_in,
  input  logic               pcm_valid,
  output logic               pcm_ready,
  output logic        [3:0]  code,
  output logic               code_valid,
  output logic signed [11:0] pred
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SUB  = 3'd1;
  localparam logic [2:0] ST_B2   = 3'd2;
  localparam logic [2:0] ST_B1   = 3'd3;
  localparam logic [2:0] ST_B0   = 3'd4;
  localparam logic [2:0] ST_UPD  = 3'd5;

  logic        [2:0]  r_state;
  logic signed [11:0] r_pcm;
  logic signed [11:0] r_pred;
  logic        [5:0]  r_idx;
  logic        [10:0] r_step;
  logic        [13:0] r_mag;
  logic               r_sign;
  logic               r_b2;
  logic               r_b1;
  logic               r_b0;
  logic        [3:0]  r_code;
  logic               r_code_valid;

  logic signed [13:0] w_diff;
  logic        [13:0] w_abs;
  logic        [13:0] w_step_full;
  logic        [13:0] w_step_half;
  logic        [13:0] w_step_qtr;
  logic               w_ge_full;
  logic               w_ge_half;
  logic               w_ge_qtr;
  logic        [11:0] w_qn;
  logic signed [13:0] w_pred_ext;
  logic signed [13:0] w_sum;
  logic signed [11:0] w_pred_next;
  logic        [6:0]  w_idx_up;
  logic        [5:0]  w_idx_next;

  function automatic logic [10:0] step_lut(input logic [5:0] i);
    logic [10:0] s;
    case (i)
      6'd0:  s = 11'd16;   6'd1:  s = 11'd17;   6'd2:  s = 11'd19;
      6'd3:  s = 11'd21;   6'd4:  s = 11'd23;   6'd5:  s = 11'd25;
      6'd6:  s = 11'd28;   6'd7:  s = 11'd31;   6'd8:  s = 11'd34;
      6'd9:  s = 11'd37;   6'd10: s = 11'd41;   6'd11: s = 11'd45;
      6'd12: s = 11'd50;   6'd13: s = 11'd55;   6'd14: s = 11'd60;
      6'd15: s = 11'd66;   6'd16: s = 11'd73;   6'd17: s = 11'd80;
      6'd18: s = 11'd88;   6'd19: s = 11'd97;   6'd20: s = 11'd107;
      6'd21: s = 11'd118;  6'd22: s = 11'd130;  6'd23: s = 11'd143;
      6'd24: s = 11'd157;  6'd25: s = 11'd173;  6'd26: s = 11'd190;
      6'd27: s = 11'd209;  6'd28: s = 11'd230;  6'd29: s = 11'd253;
      6'd30: s = 11'd279;  6'd31: s = 11'd307;  6'd32: s = 11'd337;
      6'd33: s = 11'd371;  6'd34: s = 11'd408;  6'd35: s = 11'd449;
      6'd36: s = 11'd494;  6'd37: s = 11'd544;  6'd38: s = 11'd598;
      6'd39: s = 11'd658;  6'd40: s = 11'd724;  6'd41: s = 11'd796;
      6'd42: s = 11'd876;  6'd43: s = 11'd963;  6'd44: s = 11'd1060;
      6'd45: s = 11'd1166; 6'd46: s = 11'd1282; 6'd47: s = 11'd1411;
      default: s = 11'd1552;
    endcase
    return s;
  endfunction

  always_comb begin
    // 14-bit difference cannot overflow: |pcm - pred| <= 4095
    w_diff      = $signed({{2{r_pcm[11]}}, r_pcm}) - $signed({{2{r_pred[11]}}, r_pred});
    w_abs       = w_diff[13] ? 14'(-w_diff) : 14'(w_diff);

    w_step_full = {3'b000, r_step};
    w_step_half = {4'b0000, r_step[10:1]};
    w_step_qtr  = {5'b00000, r_step[10:2]};
    w_ge_full   = (r_mag >= w_step_full);
    w_ge_half   = (r_mag >= w_step_half);
    w_ge_qtr    = (r_mag >= w_step_qtr);

    w_qn = {4'b0000, r_step[10:3]}
         + (r_b2 ? {1'b0, r_step}           : 12'd0)
         + (r_b1 ? {2'b00, r_step[10:1]}    : 12'd0)
         + (r_b0 ? {3'b000, r_step[10:2]}   : 12'd0);

    w_pred_ext = {{2{r_pred[11]}}, r_pred};
    w_sum      = r_sign ? (w_pred_ext - $signed({2'b00, w_qn}))
                        : (w_pred_ext + $signed({2'b00, w_qn}));
    if (w_sum > 14'sd2047)
      w_pred_next = 12'sd2047;
    else if (w_sum < -14'sd2048)
      w_pred_next = -12'sd2048;
    else
      w_pred_next = w_sum[11:0];

    // increment is 2,4,6,8 for {b1,b0} = 0..3
    w_idx_up = {1'b0, r_idx} + {4'b0000, r_b1, r_b0, 1'b0} + 7'd2;
    if (r_b2)
      w_idx_next = (w_idx_up > 7'd48) ? 6'd48 : w_idx_up[5:0];
    else
      w_idx_next = (r_idx == 6'd0) ? 6'd0 : r_idx - 6'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pcm        <= '0;
      r_pred       <= REST_LEVEL;
      r_idx        <= '0;
      r_step       <= '0;
      r_mag        <= '0;
      r_sign       <= 1'b0;
      r_b2         <= 1'b0;
      r_b1         <= 1'b0;
      r_b0         <= 1'b0;
      r_code       <= '0;
      r_code_valid <= 1'b0;
    end else begin
      // pulse lasts one clk regardless of cen
      r_code_valid <= 1'b0;
      if (cen) begin
        if (sync_clr) begin
          r_state <= ST_IDLE;
          r_pred  <= REST_LEVEL;
          r_idx   <= '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (pcm_valid) begin
                r_pcm   <= pcm_in;
                r_state <= ST_SUB;
              end
            end
            ST_SUB: begin
              r_sign  <= w_diff[13];
              r_mag   <= w_abs;
              r_step  <= step_lut(r_idx);
              r_state <= ST_B2;
            end
            ST_B2: begin
              r_b2 <= w_ge_full;
              if (w_ge_full) r_mag <= r_mag - w_step_full;
              r_state <= ST_B1;
            end
            ST_B1: begin
              r_b1 <= w_ge_half;
              if (w_ge_half) r_mag <= r_mag - w_step_half;
              r_state <= ST_B0;
            end
            ST_B0: begin
              r_b0    <= w_ge_qtr;
              r_state <= ST_UPD;
            end
            ST_UPD: begin
              r_pred       <= w_pred_next;
              r_idx        <= w_idx_next;
              r_code       <= {r_sign, r_b2, r_b1, r_b0};
              r_code_valid <= 1'b1;
              r_state      <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign pcm_ready  = (r_state == ST_IDLE);
  assign code       = r_code;
  assign code_valid = r_code_valid;
  assign pred       = r_pred;

endmodule
